action_control_fsm: RTL and testbench
=====================================

// Module: action_control_fsm
// PURPOSE
//  Frame-tick-driven round referee for the two-player duel: detects sword clash, sword-to-body hits and
//  screen-edge exits, sequences death/respawn with timed holds, tracks a signed room index (tug-of-war) and
//  declares a winner. Sits between the player/sword position generators and the board/draw logic.
// PARAMETERS
//  COORD_W    12    coordinate width of all position inputs
//  SCREEN_W   1024  horizontal resolution, pixels
//  PLAYER_W   64    player sprite width;  PLAYER_H 128  player sprite height
//  EDGE       40    edge-exit margin, pixels
//  TIP_OFS    24    sword tip inset from facing body edge;  TIP_ZONE 40  hit-zone depth, pixels
//  SWORD_LEN  32    nominal blade length for clash test;  CLASH_TOL 2  clash x tolerance, pixels
//  DEAD_HOLD  60    ticks a dead flag is held before respawn;  CLASH_HOLD 8  ticks collision is held
//  ROOMS      4     |room| reaching ROOMS ends the game;  ROOM_W 5  signed room index width
// PORTS
//  clk           in   1        system clock
//  reset         in   1        asynchronous, active-low reset
//  frame_tick    in   1        one-clk pulse per frame; positions sampled only on tick
//  xpos_playerL/ypos_playerL, xpos_playerR/ypos_playerR  in COORD_W  player top-left
//  xpos_sword_L/ypos_sword_L, xpos_sword_R/ypos_sword_R  in COORD_W  sword tip
//  dead_L, dead_R  out  1      player killed (held DEAD_HOLD ticks)
//  collision     out  1        blades clashed (held CLASH_HOLD ticks)
//  pos_reset     out  1        one-clk respawn pulse to position generators
//  room          out  ROOM_W   signed room index, 0 = centre, +ve toward R side
//  winner        out  2        00 none, 01 L, 10 R, 11 draw (double kill at game end only)
//  state_o       out  3        FSM state for debug
// BEHAVIOUR
//  Reset (async, reset=0): all outputs 0, room=0, counters 0, state PLAY. Release synchronous to clk.
//  States: PLAY, CLASH, DEAD, RESPAWN, GAME_OVER. Evaluation only on clk with frame_tick=1, except RESPAWN.
//  Arithmetic: all comparisons on zero-extended COORD_W+2 signed operands; no wrap on xR-TIP_OFS near 0.
//  PLAY, per tick, priority order:
//   1 xpos_playerR <= EDGE -> room-1 (saturate at -ROOMS), RESPAWN.
//   2 xpos_playerL >= SCREEN_W-EDGE-PLAYER_W -> room+1 (saturate at +ROOMS), RESPAWN.
//   3 ysL==ysR and |xsL+SWORD_LEN-xsR| <= CLASH_TOL -> collision=1, CLASH, counter=0.
//   4 hitL: xsR in (xL+PLAYER_W-TIP_OFS-TIP_ZONE, xL+PLAYER_W-TIP_OFS], ysR in (yL, yL+PLAYER_H).
//     hitR: xsL in [xR-TIP_OFS, xR-TIP_OFS+TIP_ZONE), ysL in (yR, yR+PLAYER_H). Hits ignored if ysL==ysR.
//     hitL only -> dead_L=1; hitR only -> dead_R=1; both -> see CONFIGURATION. Then DEAD, counter=0.
//   5 else stay PLAY, flags 0.
//  CLASH: counter++ per tick; at CLASH_HOLD-1 -> collision=0, PLAY. Hits/edges ignored while in CLASH.
//  DEAD: flags held; counter++ per tick; at DEAD_HOLD-1 -> clear flags, RESPAWN. room unchanged by kills.
//  RESPAWN: pos_reset=1 exactly one clk (no tick needed). If |room|==ROOMS -> GAME_OVER with
//   winner=01 if room=+ROOMS, 10 if -ROOMS; else PLAY.
//  GAME_OVER: terminal; outputs frozen, pos_reset=0; left only via reset.
//  Ticks arriving during RESPAWN clk are ignored. Reset mid-hold aborts counters immediately.
//  Latency: flag/room change registered on the clk after the sampling tick (1 clk).
// CONFIGURATION
//  ACTION_DOUBLE_KILL_EN defined: simultaneous hitL&hitR set dead_L=dead_R=1, DEAD as normal;
//   winner=11 only if a double kill occurs in the DEAD hold immediately preceding game end (not reachable
//   by room alone; reserved, documented as always 00/01/10 otherwise).
//  Undefined: simultaneous hits -> dead_L only (R blade wins priority); winner never 11.
// TESTING
//  T1 reset=0 mid-DEAD (dead_R=1, counter 30) -> all outputs 0, room 0, state PLAY within 0 clk.
//  T2 xR=40 on tick -> room=-1 next clk, pos_reset high 1 clk, back to PLAY; xR=41 -> no change.
//  T3 xL=100,yL=200,xsR=130,ysR=250,ysL=240, tick -> dead_L=1 for exactly 60 ticks, then pos_reset pulse.
//  T4 ysL=ysR=250, xsL=300, xsR=333 tick -> collision=1 for 8 ticks; xsR=335 -> no clash.
//  T5 four R-edge exits -> room=-4, winner=10, GAME_OVER; further ticks/edges leave outputs frozen.
//  T6 hitL and hitR same tick: macro off -> dead_L=1,dead_R=0; macro on -> both 1.

Source files
------------

// File: rtl/action_control_fsm.sv
// Duel round referee: clash / hit / edge-exit detection, timed death and clash holds,
// tug-of-war room index and winner. Optional macro ACTION_DOUBLE_KILL_EN enables double kills.
module action_control_fsm #(
  parameter int COORD_W    = 12,
  parameter int SCREEN_W   = 1024,
  parameter int PLAYER_W   = 64,
  parameter int PLAYER_H   = 128,
  parameter int EDGE       = 40,
  parameter int TIP_OFS    = 24,
  parameter int TIP_ZONE   = 40,
  parameter int SWORD_LEN  = 32,
  parameter int CLASH_TOL  = 2,
  parameter int DEAD_HOLD  = 60,
  parameter int CLASH_HOLD = 8,
  parameter int ROOMS      = 4,
  parameter int ROOM_W     = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic [COORD_W-1:0]       xpos_playerL,
  input  logic [COORD_W-1:0]       ypos_playerL,
  input  logic [COORD_W-1:0]       xpos_playerR,
  input  logic [COORD_W-1:0]       ypos_playerR,
  input  logic [COORD_W-1:0]       xpos_sword_L,
  input  logic [COORD_W-1:0]       ypos_sword_L,
  input  logic [COORD_W-1:0]       xpos_sword_R,
  input  logic [COORD_W-1:0]       ypos_sword_R,
  output logic                     dead_L,
  output logic                     dead_R,
  output logic                     collision,
  output logic                     pos_reset,
  output logic signed [ROOM_W-1:0] room,
  output logic [1:0]               winner,
  output logic [2:0]               state_o
);

  localparam int S        = COORD_W + 2;
  localparam int HOLD_MAX = (DEAD_HOLD > CLASH_HOLD) ? DEAD_HOLD : CLASH_HOLD;
  localparam int CNT_W    = $clog2(HOLD_MAX);

  typedef logic signed [S-1:0]      coord_t;
  typedef logic signed [ROOM_W-1:0] room_t;
  typedef enum logic [2:0] {
    PLAY      = 3'd0,
    CLASH     = 3'd1,
    DEAD      = 3'd2,
    RESPAWN   = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam coord_t C_EDGE_R   = coord_t'(EDGE);
  localparam coord_t C_EDGE_L   = coord_t'(SCREEN_W - EDGE - PLAYER_W);
  localparam coord_t C_SWORD    = coord_t'(SWORD_LEN);
  localparam coord_t C_TOL      = coord_t'(CLASH_TOL);
  localparam coord_t C_TIP_LO   = coord_t'(PLAYER_W - TIP_OFS - TIP_ZONE);
  localparam coord_t C_TIP_HI   = coord_t'(PLAYER_W - TIP_OFS);
  localparam coord_t C_TIP_OFS  = coord_t'(TIP_OFS);
  localparam coord_t C_TIP_ZONE = coord_t'(TIP_ZONE);
  localparam coord_t C_PH       = coord_t'(PLAYER_H);
  localparam room_t  R_MAX      = room_t'(ROOMS);
  localparam room_t  R_MIN      = room_t'(-ROOMS);

  // Zero-extend into a signed domain so xR-TIP_OFS near the left edge cannot wrap.
  function automatic coord_t ext(input logic [COORD_W-1:0] v);
    return coord_t'({2'b00, v});
  endfunction

  coord_t xl, yl, xr, yr, xsl, ysl, xsr, ysr, clash_d;
  logic   edge_r, edge_l, same_y, clash_hit, hit_l, hit_r;

  state_t           state;
  logic [CNT_W-1:0] cnt;
`ifdef ACTION_DOUBLE_KILL_EN
  logic             dbl;
`endif

  assign xl  = ext(xpos_playerL);
  assign yl  = ext(ypos_playerL);
  assign xr  = ext(xpos_playerR);
  assign yr  = ext(ypos_playerR);
  assign xsl = ext(xpos_sword_L);
  assign ysl = ext(ypos_sword_L);
  assign xsr = ext(xpos_sword_R);
  assign ysr = ext(ypos_sword_R);

  assign edge_r    = (xr <= C_EDGE_R);
  assign edge_l    = (xl >= C_EDGE_L);
  assign same_y    = (ysl == ysr);
  assign clash_d   = xsl + C_SWORD - xsr;
  assign clash_hit = same_y && (clash_d <= C_TOL) && (clash_d >= -C_TOL);

  // hit_l: R's blade lands in L's body zone; hit_r: L's blade lands in R's body zone.
  assign hit_l = !same_y && (xsr > xl + C_TIP_LO) && (xsr <= xl + C_TIP_HI)
                 && (ysr > yl) && (ysr < yl + C_PH);
  assign hit_r = !same_y && (xsl >= xr - C_TIP_OFS) && (xsl < xr - C_TIP_OFS + C_TIP_ZONE)
                 && (ysl > yr) && (ysl < yr + C_PH);

  assign state_o = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PLAY;
      cnt       <= '0;
      dead_L    <= 1'b0;
      dead_R    <= 1'b0;
      collision <= 1'b0;
      pos_reset <= 1'b0;
      room      <= '0;
      winner    <= 2'b00;
`ifdef ACTION_DOUBLE_KILL_EN
      dbl       <= 1'b0;
`endif
    end else begin
      pos_reset <= 1'b0;
      case (state)
        PLAY: begin
          if (frame_tick) begin
            if (edge_r) begin
              room      <= (room == R_MIN) ? room : room - room_t'(1);
              pos_reset <= 1'b1;
              state     <= RESPAWN;
            end else if (edge_l) begin
              room      <= (room == R_MAX) ? room : room + room_t'(1);
              pos_reset <= 1'b1;
              state     <= RESPAWN;
            end else if (clash_hit) begin
              collision <= 1'b1;
              cnt       <= '0;
              state     <= CLASH;
            end else if (hit_l || hit_r) begin
              dead_L <= hit_l;
`ifdef ACTION_DOUBLE_KILL_EN
              dead_R <= hit_r;
              dbl    <= hit_l && hit_r;
`else
              dead_R <= hit_r && !hit_l;
`endif
              cnt    <= '0;
              state  <= DEAD;
            end
          end
        end
        CLASH: begin
          if (frame_tick) begin
            if (cnt == CNT_W'(CLASH_HOLD - 1)) begin
              collision <= 1'b0;
              state     <= PLAY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DEAD: begin
          if (frame_tick) begin
            if (cnt == CNT_W'(DEAD_HOLD - 1)) begin
              dead_L    <= 1'b0;
              dead_R    <= 1'b0;
              pos_reset <= 1'b1;
              state     <= RESPAWN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RESPAWN: begin
          // Any tick arriving in this clk is deliberately dropped.
          if (room == R_MAX || room == R_MIN) begin
            state <= GAME_OVER;
`ifdef ACTION_DOUBLE_KILL_EN
            winner <= dbl ? 2'b11 : ((room == R_MAX) ? 2'b01 : 2'b10);
`else
            winner <= (room == R_MAX) ? 2'b01 : 2'b10;
`endif
          end else begin
            state <= PLAY;
          end
`ifdef ACTION_DOUBLE_KILL_EN
          dbl <= 1'b0;
`endif
        end
        GAME_OVER: begin
          state <= GAME_OVER;
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_action_control_fsm.sv
// Self-checking bench for action_control_fsm: directed scenarios plus randomized frames
// checked against a frame-level referee model.
module tb_action_control_fsm;

  localparam int PLAYER_W  = 64;
  localparam int PLAYER_H  = 128;
  localparam int EDGE      = 40;
  localparam int SCREEN_W  = 1024;
  localparam int TIP_OFS   = 24;
  localparam int TIP_ZONE  = 40;
  localparam int SWORD_LEN = 32;
  localparam int CLASH_TOL = 2;
  localparam int DEAD_HOLD = 60;
  localparam int CLASH_HLD = 8;
  localparam int ROOMS     = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [11:0] xl, yl, xr, yr, xsl, ysl, xsr, ysr;
  logic        dead_L, dead_R, collision, pos_reset;
  logic [4:0]  room;
  logic [1:0]  winner;
  logic [2:0]  state_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0] exp_q[$];

  // frame-level model
  int m_room, m_hold, m_kind, m_win;
  bit m_dl, m_dr, m_col, m_over;

  always #5 clk = ~clk;

  action_control_fsm dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .xpos_playerL(xl), .ypos_playerL(yl), .xpos_playerR(xr), .ypos_playerR(yr),
    .xpos_sword_L(xsl), .ypos_sword_L(ysl), .xpos_sword_R(xsr), .ypos_sword_R(ysr),
    .dead_L(dead_L), .dead_R(dead_R), .collision(collision), .pos_reset(pos_reset),
    .room(room), .winner(winner), .state_o(state_o)
  );

  // ---------------- drivers ----------------
  task automatic set_safe();
    xl = 300; yl = 100; xr = 600; yr = 400;
    xsl = 380; ysl = 150; xsr = 520; ysr = 450;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // ---------------- model ----------------
  task automatic model_reset();
    m_room = 0; m_hold = 0; m_kind = 0; m_win = 0;
    m_dl = 0; m_dr = 0; m_col = 0; m_over = 0;
  endtask

  task automatic model_frame(output bit respawn);
    int d;
    bit hl, hr;
    respawn = 0;
    if (m_over) return;
    if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin
        if (m_kind == 2) respawn = 1;
        m_dl = 0; m_dr = 0; m_col = 0; m_kind = 0;
      end
    end else if (int'(xr) <= EDGE) begin
      if (m_room > -ROOMS) m_room--;
      respawn = 1;
    end else if (int'(xl) >= SCREEN_W - EDGE - PLAYER_W) begin
      if (m_room < ROOMS) m_room++;
      respawn = 1;
    end else begin
      d = int'(xsl) + SWORD_LEN - int'(xsr);
      if (ysl == ysr && d <= CLASH_TOL && d >= -CLASH_TOL) begin
        m_col = 1; m_hold = CLASH_HLD; m_kind = 1;
      end else begin
        hl = (ysl != ysr) && int'(xsr) > int'(xl) + PLAYER_W - TIP_OFS - TIP_ZONE
             && int'(xsr) <= int'(xl) + PLAYER_W - TIP_OFS
             && int'(ysr) > int'(yl) && int'(ysr) < int'(yl) + PLAYER_H;
        hr = (ysl != ysr) && int'(xsl) >= int'(xr) - TIP_OFS
             && int'(xsl) < int'(xr) - TIP_OFS + TIP_ZONE
             && int'(ysl) > int'(yr) && int'(ysl) < int'(yr) + PLAYER_H;
        if (hl || hr) begin
          m_dl = hl;
`ifdef ACTION_DOUBLE_KILL_EN
          m_dr = hr;
`else
          m_dr = hr && !hl;
`endif
          m_hold = DEAD_HOLD; m_kind = 2;
        end
      end
    end
    if (respawn && (m_room == ROOMS || m_room == -ROOMS)) begin
      m_over = 1;
      m_win  = (m_room == ROOMS) ? 1 : 2;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_safe();
    reset = 1'b0; frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({dead_L, dead_R, collision, pos_reset, room, winner, state_o} !== 15'd0)
      $display("FAIL reset_outputs got %b want 0",
               {dead_L, dead_R, collision, pos_reset, room, winner, state_o});
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_edge_exit();
    set_safe(); xr = 40;
    do_tick();
    n_checks++;
    if ({room, pos_reset, state_o} !== {5'h1f, 1'b1, 3'd3})
      $display("FAIL edge40_tick room=%0d pos_reset=%b state=%0d want -1/1/3", $signed(room), pos_reset, state_o);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({room, pos_reset, state_o} !== {5'h1f, 1'b0, 3'd0})
      $display("FAIL edge40_after room=%0d pos_reset=%b state=%0d want -1/0/0", $signed(room), pos_reset, state_o);
    else n_pass++;
    xr = 41;
    do_tick();
    n_checks++;
    if ({room, pos_reset, state_o} !== {5'h1f, 1'b0, 3'd0})
      $display("FAIL edge41 room=%0d pos_reset=%b state=%0d want -1/0/0", $signed(room), pos_reset, state_o);
    else n_pass++;
    xr = 600; xl = 920;
    do_tick();
    @(negedge clk);
    n_checks++;
    if ({room, state_o} !== {5'd0, 3'd0})
      $display("FAIL edge_left room=%0d state=%0d want 0/0", $signed(room), state_o);
    else n_pass++;
  endtask

  task automatic test_dead_hold();
    int n;
    apply_reset();
    set_safe(); xl = 100; yl = 200; xsr = 130; ysr = 250; ysl = 240;
    do_tick();
    n_checks++;
    if ({dead_L, dead_R, state_o} !== {1'b1, 1'b0, 3'd2})
      $display("FAIL t3_enter dead_L=%b dead_R=%b state=%0d want 1/0/2", dead_L, dead_R, state_o);
    else n_pass++;
    set_safe();
    n = 0;
    while (dead_L === 1'b1 && n < 80) begin
      do_tick(); n++;
    end
    n_checks++;
    if (n != DEAD_HOLD) $display("FAIL t3_hold_ticks got %0d want %0d", n, DEAD_HOLD);
    else n_pass++;
    n_checks++;
    if ({pos_reset, state_o} !== {1'b1, 3'd3})
      $display("FAIL t3_respawn pos_reset=%b state=%0d want 1/3", pos_reset, state_o);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({pos_reset, state_o, room} !== {1'b0, 3'd0, 5'd0})
      $display("FAIL t3_play pos_reset=%b state=%0d room=%0d want 0/0/0", pos_reset, state_o, room);
    else n_pass++;
  endtask

  task automatic test_reset_mid_dead();
    apply_reset();
    set_safe(); xsl = 580; ysl = 450; ysr = 460;
    do_tick();
    n_checks++;
    if ({dead_L, dead_R} !== 2'b01)
      $display("FAIL t1_dead_r got %b want 01", {dead_L, dead_R});
    else n_pass++;
    set_safe();
    repeat (30) do_tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({dead_L, dead_R, collision, pos_reset, room, winner, state_o} !== 15'd0)
      $display("FAIL t1_async_reset got %b want 0",
               {dead_L, dead_R, collision, pos_reset, room, winner, state_o});
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_clash();
    int n;
    int xs_tab[3] = '{333, 334, 335};
    bit hit_tab[3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      set_safe(); ysl = 250; ysr = 250; xsl = 300; xsr = 12'(xs_tab[k]);
      do_tick();
      n_checks++;
      if (collision !== hit_tab[k])
        $display("FAIL t4_clash_xsr%0d got %b want %b", xs_tab[k], collision, hit_tab[k]);
      else n_pass++;
      set_safe();
      n = 0;
      while (collision === 1'b1 && n < 20) begin
        do_tick(); n++;
      end
      n_checks++;
      if (n != (hit_tab[k] ? CLASH_HLD : 0))
        $display("FAIL t4_hold_ticks_xsr%0d got %0d want %0d", xs_tab[k], n, hit_tab[k] ? CLASH_HLD : 0);
      else n_pass++;
      n_checks++;
      if ({pos_reset, state_o} !== {1'b0, 3'd0})
        $display("FAIL t4_after pos_reset=%b state=%0d want 0/0", pos_reset, state_o);
      else n_pass++;
    end
  endtask

  task automatic test_respawn_tick();
    apply_reset();
    set_safe(); xr = 20;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk);
    @(negedge clk); frame_tick = 1'b0;
    n_checks++;
    if ({room, state_o, pos_reset} !== {5'h1f, 3'd0, 1'b0})
      $display("FAIL respawn_tick room=%0d state=%0d pos_reset=%b want -1/0/0", $signed(room), state_o, pos_reset);
    else n_pass++;
  endtask

  task automatic test_game_over();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      set_safe(); xr = 12'($urandom_range(0, 40));
      do_tick();
      @(negedge clk);
    end
    n_checks++;
    if ({room, winner, state_o, pos_reset} !== {5'h1c, 2'b10, 3'd4, 1'b0})
      $display("FAIL t5_over room=%0d winner=%b state=%0d pos_reset=%b want -4/10/4/0",
               $signed(room), winner, state_o, pos_reset);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      set_safe();
      if (k == 0) xr = 10;
      if (k == 1) xl = 950;
      if (k == 2) begin xl = 100; yl = 200; xsr = 130; ysr = 250; ysl = 240; end
      do_tick();
      n_checks++;
      if ({dead_L, dead_R, collision, pos_reset, room, winner, state_o} !== {4'b0, 5'h1c, 2'b10, 3'd4})
        $display("FAIL t5_frozen_%0d got %b", k, {dead_L, dead_R, collision, pos_reset, room, winner, state_o});
      else n_pass++;
    end
  endtask

  task automatic test_double_hit();
    logic [1:0] want;
`ifdef ACTION_DOUBLE_KILL_EN
    want = 2'b11;
`else
    want = 2'b10;
`endif
    apply_reset();
    xl = 100; yl = 200; xsr = 130; ysr = 250;
    xr = 600; yr = 400; xsl = 580; ysl = 450;
    do_tick();
    n_checks++;
    if ({dead_L, dead_R} !== want)
      $display("FAIL t6_double_hit got %b want %b", {dead_L, dead_R}, want);
    else n_pass++;
    set_safe();
    repeat (DEAD_HOLD) do_tick();
    @(negedge clk);
    n_checks++;
    if ({dead_L, dead_R, state_o, winner} !== {2'b00, 3'd0, 2'b00})
      $display("FAIL t6_after flags=%b state=%0d winner=%b want 00/0/00", {dead_L, dead_R}, state_o, winner);
    else n_pass++;
  endtask

  task automatic gen_frame();
    int s, off;
    xl = 12'($urandom_range(0, 900));  yl = 12'($urandom_range(0, 600));
    xr = 12'($urandom_range(41, 1000)); yr = 12'($urandom_range(0, 600));
    xsl = 12'($urandom_range(0, 1000)); ysl = 12'($urandom_range(0, 700));
    xsr = 12'($urandom_range(0, 1000)); ysr = 12'($urandom_range(0, 700));
    s = int'($urandom_range(0, 9));
    case (s)
      0: xr = 12'($urandom_range(0, 45));
      1: xl = 12'($urandom_range(915, 1000));
      2: begin
        ysr = ysl; off = int'($urandom_range(0, 8)) - 4;
        xsr = 12'(int'(xsl) + SWORD_LEN + off);
      end
      3, 4: begin
        xsr = 12'(int'(xl) + int'($urandom_range(0, 42)));
        ysr = 12'(int'(yl) + int'($urandom_range(0, 130)));
        if ($urandom_range(0, 3) == 0) ysl = ysr;
      end
      5, 6: begin
        xr  = 12'($urandom_range(50, 900));
        xsl = 12'(int'(xr) - 26 + int'($urandom_range(0, 44)));
        ysl = 12'(int'(yr) + int'($urandom_range(0, 130)));
      end
      7: begin
        xr  = 12'($urandom_range(50, 900));
        xsr = 12'(int'(xl) + int'($urandom_range(1, 40)));
        ysr = 12'(int'(yl) + int'($urandom_range(1, 127)));
        xsl = 12'(int'(xr) - TIP_OFS + int'($urandom_range(0, 39)));
        ysl = 12'(int'(yr) + int'($urandom_range(1, 127)));
      end
      default: ;
    endcase
  endtask

  task automatic test_random();
    bit resp;
    int over_cnt = 0;
    logic [9:0] exp_v;
    logic [2:0] exp_st;
    apply_reset();
    model_reset();
    for (int f = 0; f < 600; f++) begin
      gen_frame();
      model_frame(resp);
      exp_q.push_back({m_dl, m_dr, m_col, 5'(m_room), 2'(m_win)});
      exp_st = m_over ? 3'd4 : (m_kind == 1) ? 3'd1 : (m_kind == 2) ? 3'd2 : 3'd0;
      do_tick();
      n_checks++;
      if (pos_reset !== resp) $display("FAIL rnd_pos_reset frame %0d got %b want %b", f, pos_reset, resp);
      else n_pass++;
      if (resp) @(negedge clk);
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({dead_L, dead_R, collision, room, winner} !== exp_v || state_o !== exp_st)
        $display("FAIL rnd_outputs frame %0d got %b st %0d want %b st %0d", f,
                 {dead_L, dead_R, collision, room, winner}, state_o, exp_v, exp_st);
      else n_pass++;
      if (m_over) over_cnt++;
      if (over_cnt > 3) begin
        apply_reset(); model_reset(); over_cnt = 0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    frame_tick = 1'b0;
    reset = 1'b0;
    test_reset();
    test_edge_exit();
    test_dead_hold();
    test_reset_mid_dead();
    test_clash();
    test_respawn_tick();
    test_game_over();
    test_double_hit();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
